// File: rtl/insn_mem_port.sv
// -----------------------------------------------------------------------------
// insn_mem_port
//
// Responder end of the L1 instruction-cache line-fill bus. Each 64-bit qword
// request from the cache is serviced with two 32-bit reads of the word-wide
// instruction memory (even word first, then odd word). The two words are
// assembled little-endian and returned with a one-cycle ready pulse. A one-entry
// last-line buffer answers a repeated qword address without touching memory.
//
// Ports
//   clk                 in   clock, all state on the rising edge
//   rst_n               in   asynchronous reset, ACTIVE HIGH despite the name
//   insn_start          in   cache request, held until insn_ready
//   insn_addr   [27:0]  in   qword address
//   insn_ready          out  one-cycle pulse, insn_data_rd valid
//   insn_data_rd[63:0]  out  returned qword (zero outside the ready cycle)
//   flush               in   invalidates the last-line buffer
//   mem_read            out  word read request, held until accepted
//   mem_addr    [28:0]  out  word address {qaddr, beat}
//   mem_waitrequest     in   1 = read not accepted this cycle
//   mem_readdata[31:0]  in   read data
//   mem_readdata_valid  in   read data valid (accept cycle or later)
//   cnt_hit     [15:0]  out  buffer-hit count, saturating
//   cnt_miss    [15:0]  out  miss count, saturating
//
// Parameter
//   BUF_EN              1 enables the last-line buffer, 0 = every request misses
// -----------------------------------------------------------------------------
module insn_mem_port #(
   parameter bit BUF_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        insn_start,
   input  logic [27:0] insn_addr,
   output logic        insn_ready,
   output logic [63:0] insn_data_rd,
   input  logic        flush,
   output logic        mem_read,
   output logic [28:0] mem_addr,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   input  logic        mem_readdata_valid,
   output logic [15:0] cnt_hit,
   output logic [15:0] cnt_miss
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ0  = 3'd1,
      S_WAIT0 = 3'd2,
      S_REQ1  = 3'd3,
      S_WAIT1 = 3'd4,
      S_RESP  = 3'd5
   } state_e;

   // Saturating 16-bit increment used by both statistics counters.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

   state_e      state_q, state_d;
   logic [27:0] qaddr_q, qaddr_d;
   logic [31:0] lo_q, lo_d;
   logic        miss_q, miss_d;
   logic        flush_seen_q, flush_seen_d;
   logic        buf_valid_q, buf_valid_d;
   logic [27:0] buf_addr_q, buf_addr_d;
   logic [63:0] buf_data_q, buf_data_d;
   logic [15:0] cnt_hit_q, cnt_hit_d;
   logic [15:0] cnt_miss_q, cnt_miss_d;
   logic        insn_ready_q, insn_ready_d;
   logic [63:0] insn_data_q, insn_data_d;
   logic        mem_read_q, mem_read_d;
   logic [28:0] mem_addr_q, mem_addr_d;

   logic        hit_s;
   logic [63:0] qword_s;
   logic        beat_s;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d      = state_q;
      qaddr_d      = qaddr_q;
      lo_d         = lo_q;
      miss_d       = miss_q;
      // A flush anywhere in a transaction blocks that transaction's buffer fill.
      flush_seen_d = flush_seen_q | flush;
      buf_valid_d  = buf_valid_q & ~flush;
      buf_addr_d   = buf_addr_q;
      buf_data_d   = buf_data_q;
      cnt_hit_d    = cnt_hit_q;
      cnt_miss_d   = cnt_miss_q;
      hit_s        = 1'b0;
      qword_s      = 64'h0;

      case (state_q)
         S_IDLE: begin
            flush_seen_d = flush;
            if (insn_start) begin
               qaddr_d = insn_addr;
               // A flush in the request cycle turns a would-be hit into a miss.
               hit_s = (BUF_EN == 1'b1) && buf_valid_q &&
                       (buf_addr_q == insn_addr) && !flush;
               if (hit_s) begin
                  state_d   = S_RESP;
                  miss_d    = 1'b0;
                  qword_s   = buf_data_q;
                  cnt_hit_d = sat_inc(cnt_hit_q);
               end else begin
                  state_d    = S_REQ0;
                  miss_d     = 1'b1;
                  cnt_miss_d = sat_inc(cnt_miss_q);
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_REQ0: begin
            if (!mem_waitrequest) begin
               if (mem_readdata_valid) begin
                  lo_d    = mem_readdata;
                  state_d = S_REQ1;
               end else begin
                  state_d = S_WAIT0;
               end
            end else begin
               state_d = S_REQ0;
            end
         end

         S_WAIT0: begin
            if (mem_readdata_valid) begin
               lo_d    = mem_readdata;
               state_d = S_REQ1;
            end else begin
               state_d = S_WAIT0;
            end
         end

         S_REQ1: begin
            if (!mem_waitrequest) begin
               if (mem_readdata_valid) begin
                  qword_s = {mem_readdata, lo_q};
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT1;
               end
            end else begin
               state_d = S_REQ1;
            end
         end

         S_WAIT1: begin
            if (mem_readdata_valid) begin
               qword_s = {mem_readdata, lo_q};
               state_d = S_RESP;
            end else begin
               state_d = S_WAIT1;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
            // The returned qword still sits in insn_data_q during RESP.
            if ((BUF_EN == 1'b1) && miss_q && !flush_seen_q && !flush) begin
               buf_valid_d = 1'b1;
               buf_addr_d  = qaddr_q;
               buf_data_d  = insn_data_q;
            end else begin
               buf_valid_d = buf_valid_q & ~flush;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they never depend
      // combinationally on inputs.
      beat_s       = (state_d == S_REQ1) || (state_d == S_WAIT1);
      insn_ready_d = (state_d == S_RESP);
      insn_data_d  = (state_d == S_RESP) ? qword_s : 64'h0;
      mem_read_d   = (state_d == S_REQ0) || (state_d == S_REQ1);
      mem_addr_d   = {qaddr_d, beat_s};
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q      <= S_IDLE;
         qaddr_q      <= 28'h0;
         lo_q         <= 32'h0;
         miss_q       <= 1'b0;
         flush_seen_q <= 1'b0;
         buf_valid_q  <= 1'b0;
         buf_addr_q   <= 28'h0;
         buf_data_q   <= 64'h0;
         cnt_hit_q    <= 16'h0;
         cnt_miss_q   <= 16'h0;
         insn_ready_q <= 1'b0;
         insn_data_q  <= 64'h0;
         mem_read_q   <= 1'b0;
         mem_addr_q   <= 29'h0;
      end else begin
         state_q      <= state_d;
         qaddr_q      <= qaddr_d;
         lo_q         <= lo_d;
         miss_q       <= miss_d;
         flush_seen_q <= flush_seen_d;
         buf_valid_q  <= buf_valid_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         cnt_hit_q    <= cnt_hit_d;
         cnt_miss_q   <= cnt_miss_d;
         insn_ready_q <= insn_ready_d;
         insn_data_q  <= insn_data_d;
         mem_read_q   <= mem_read_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   assign insn_ready   = insn_ready_q;
   assign insn_data_rd = insn_data_q;
   assign mem_read     = mem_read_q;
   assign mem_addr     = mem_addr_q;
   assign cnt_hit      = cnt_hit_q;
   assign cnt_miss     = cnt_miss_q;

endmodule

// File: tb/tb_insn_mem_port.sv
module tb_insn_mem_port;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        insn_start = 1'b0;
   logic [27:0] insn_addr = 28'h0;
   logic        insn_ready;
   logic [63:0] insn_data_rd;
   logic        flush = 1'b0;
   logic        mem_read;
   logic [28:0] mem_addr;
   logic        mem_waitrequest = 1'b0;
   logic [31:0] mem_readdata = 32'h0;
   logic        mem_readdata_valid = 1'b0;
   logic [15:0] cnt_hit, cnt_miss;

   // second instance with the buffer disabled, fed by a trivial zero-wait memory
   logic        nb_start = 1'b0;
   logic [27:0] nb_addr = 28'h0;
   logic        nb_ready;
   logic [63:0] nb_data;
   logic        nb_flush = 1'b0;
   logic        nb_mem_read;
   logic [28:0] nb_mem_addr;
   logic        nb_waitreq;
   logic [31:0] nb_rdata;
   logic        nb_valid;
   logic [15:0] nb_cnt_hit, nb_cnt_miss;

   assign nb_waitreq = 1'b0;
   assign nb_valid   = nb_mem_read;
   assign nb_rdata   = {3'b000, nb_mem_addr};

   insn_mem_port #(.BUF_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst), .insn_start(insn_start), .insn_addr(insn_addr),
      .insn_ready(insn_ready), .insn_data_rd(insn_data_rd), .flush(flush),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_waitrequest(mem_waitrequest),
      .mem_readdata(mem_readdata), .mem_readdata_valid(mem_readdata_valid),
      .cnt_hit(cnt_hit), .cnt_miss(cnt_miss)
   );

   insn_mem_port #(.BUF_EN(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst), .insn_start(nb_start), .insn_addr(nb_addr),
      .insn_ready(nb_ready), .insn_data_rd(nb_data), .flush(nb_flush),
      .mem_read(nb_mem_read), .mem_addr(nb_mem_addr), .mem_waitrequest(nb_waitreq),
      .mem_readdata(nb_rdata), .mem_readdata_valid(nb_valid),
      .cnt_hit(nb_cnt_hit), .cnt_miss(nb_cnt_miss)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [31:0] mem_words [logic [28:0]];

   function automatic logic [31:0] word_at(input logic [28:0] a);
      if (!mem_words.exists(a)) mem_words[a] = $urandom;
      return mem_words[a];
   endfunction

   int          cfg_w = 0;       // waitrequest cycles per beat
   int          cfg_d = 0;       // valid delay after accept
   int          acc_cnt = 0;
   int          hold_err = 0;
   logic [28:0] acc_q [$];
   bit          req_act = 1'b0;
   bit          pend = 1'b0;
   int          wcnt = 0;
   int          dcnt = 0;
   logic [28:0] pend_addr = 29'h0;

   always @(negedge clk) begin
      mem_readdata_valid = 1'b0;
      mem_waitrequest    = 1'b0;
      mem_readdata       = $urandom;
      if (rst) req_act = 1'b0;
      if (pend) begin
         if (mem_read) hold_err++;
         dcnt--;
         if (dcnt <= 0) begin
            mem_readdata_valid = 1'b1;
            mem_readdata       = word_at(pend_addr);
            pend               = 1'b0;
         end
      end else if (mem_read) begin
         if (!req_act) begin
            req_act = 1'b1;
            wcnt    = cfg_w;
         end
         if (wcnt > 0) begin
            mem_waitrequest = 1'b1;
            wcnt--;
         end else begin
            req_act = 1'b0;
            acc_cnt++;
            acc_q.push_back(mem_addr);
            if (cfg_d == 0) begin
               mem_readdata_valid = 1'b1;
               mem_readdata       = word_at(mem_addr);
            end else begin
               pend      = 1'b1;
               pend_addr = mem_addr;
               dcnt      = cfg_d;
            end
         end
      end else if (req_act) begin
         hold_err++;   // request withdrawn before acceptance
      end
   end

   // ---------------- reference model ----------------
   bit          m_valid = 1'b0;
   logic [27:0] m_addr = 28'h0;
   logic [63:0] m_data = 64'h0;
   logic [15:0] m_hit = 16'h0;
   logic [15:0] m_miss = 16'h0;

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // fc: cycle in which flush is pulsed (0 = with the request), -1 none, -2 random
   task automatic do_req(input logic [27:0] a, input int fc_in);
      int lat, lmiss, cyc, acc0, q0, fc;
      bit hit, got, flushed;
      logic [63:0] exp_data;
      fc    = fc_in;
      lmiss = 1 + 2 * (1 + cfg_w + cfg_d);
      if (fc == -2) fc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lmiss) : -1;
      hit = m_valid && (m_addr == a) && (fc != 0);
      if (hit && fc > 1) fc = 1;
      lat      = hit ? 1 : lmiss;
      flushed  = (fc >= 0) && (fc <= lat);
      exp_data = hit ? m_data : {word_at({a, 1'b1}), word_at({a, 1'b0})};
      acc0 = acc_cnt;
      q0   = acc_q.size();
      insn_addr  = a;
      insn_start = 1'b1;
      flush      = (fc == 0);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 300) begin
         @(negedge clk);
         cyc++;
         flush = (cyc == fc);
         if (insn_ready === 1'b1) got = 1'b1;
      end
      insn_start = 1'b0;
      check_eq("ready_seen", got, 1);
      check_eq("latency", cyc, lat);
      check_eq("data", insn_data_rd, exp_data);
      if (hit) m_hit = sat16(m_hit);
      else     m_miss = sat16(m_miss);
      if (flushed) m_valid = 1'b0;
      else if (!hit) begin
         m_valid = 1'b1;
         m_addr  = a;
         m_data  = exp_data;
      end
      check_eq("cnt_hit", cnt_hit, m_hit);
      check_eq("cnt_miss", cnt_miss, m_miss);
      check_eq("mem_reads", acc_cnt - acc0, hit ? 0 : 2);
      if (!hit && acc_q.size() >= q0 + 2) begin
         check_eq("mem_addr_beat0", acc_q[q0], {a, 1'b0});
         check_eq("mem_addr_beat1", acc_q[q0 + 1], {a, 1'b1});
      end
      @(negedge clk);
      flush = 1'b0;
      check_eq("ready_pulse", insn_ready, 0);
   endtask

   logic [27:0] pool [4];

   initial begin
      int nready, cyc;
      bit got;
      pool[0] = 28'h0000010; pool[1] = 28'h0000005;
      pool[2] = 28'h0000077; pool[3] = 28'hFFFFFFF;

      // reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ready", insn_ready, 0);
      check_eq("rst_data", insn_data_rd, 0);
      check_eq("rst_mem_read", mem_read, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_cnt_hit", cnt_hit, 0);
      check_eq("rst_cnt_miss", cnt_miss, 0);
      rst = 1'b0;
      @(negedge clk);

      // first miss, zero-wait same-cycle memory
      mem_words[29'h0000020] = 32'h11111111;
      mem_words[29'h0000021] = 32'h22222222;
      cfg_w = 0; cfg_d = 0;
      do_req(28'h0000010, -1);
      // repeat -> buffer hit
      do_req(28'h0000010, -1);

      // slow memory: 2 waitrequest cycles, valid 3 cycles after accept
      cfg_w = 2; cfg_d = 3;
      do_req(28'h0000033, -1);

      // flush during WAIT1 of a miss, then same address misses again
      cfg_w = 0; cfg_d = 2;
      do_req(28'h0000005, 5);
      do_req(28'h0000005, -1);

      // flush with a matching request in the same cycle -> miss
      cfg_d = 0;
      do_req(28'h0000044, -1);
      do_req(28'h0000044, 0);
      do_req(28'h0000044, -1);

      // reset during WAIT0 of a miss, stray valid afterwards
      cfg_d = 5;
      insn_addr  = 28'h0000045;
      insn_start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      insn_start = 1'b0;
      #1;
      check_eq("rst_abort_ready", insn_ready, 0);
      check_eq("rst_abort_mem_read", mem_read, 0);
      @(negedge clk);
      rst = 1'b0;
      m_valid = 1'b0; m_hit = 16'h0; m_miss = 16'h0;
      check_eq("rst_abort_cnt_hit", cnt_hit, m_hit);
      check_eq("rst_abort_cnt_miss", cnt_miss, m_miss);
      nready = 0;
      repeat (12) begin
         @(negedge clk);
         if (insn_ready === 1'b1) nready++;
      end
      check_eq("stray_no_ready", nready, 0);
      cfg_d = 0;
      do_req(28'h0000044, -1);

      // miss counter saturation
      force dut.cnt_miss_q = 16'hFFFE;
      #1;
      release dut.cnt_miss_q;
      m_miss = 16'hFFFE;
      for (int k = 0; k < 3; k++) do_req(28'h0000100 + 28'(k), -1);
      check_eq("cnt_miss_sat", cnt_miss, 16'hFFFF);

      // randomized traffic
      for (int k = 0; k < 60; k++) begin
         cfg_w = $urandom_range(0, 2);
         cfg_d = $urandom_range(0, 2);
         do_req(pool[$urandom_range(0, 3)], -2);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // buffer disabled: identical requests always read memory
      for (int k = 0; k < 3; k++) begin
         nb_addr  = 28'h0000123;
         nb_start = 1'b1;
         cyc = 0;
         got = 1'b0;
         while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (nb_ready === 1'b1) got = 1'b1;
         end
         nb_start = 1'b0;
         check_eq("nb_latency", cyc, 3);
         check_eq("nb_data", nb_data, {3'b000, 28'h0000123, 1'b1, 3'b000, 28'h0000123, 1'b0});
         check_eq("nb_cnt_hit", nb_cnt_hit, 0);
         check_eq("nb_cnt_miss", nb_cnt_miss, k + 1);
         @(negedge clk);
      end

      check_eq("mem_read_hold", hold_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
